// File: rtl/serial_deserializer_if.sv
// Serial line and parallel word bundle between an upstream bit source and the deserializer.
// Latency: none, wires only.
// Backpressure: none; the receiver always accepts a bit on every falling edge of C.
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             D;   // serial line, idles low
    logic [WIDTH-1:0] Q;   // last correctly received word
    logic             V;   // one-period word-valid pulse
    logic             E;   // one-period frame-error pulse

    // Bit source side: drives the line, observes the results.
    modport master (
        output D,
        input  Q,
        input  V,
        input  E
    );

    // Receiver side: consumes the line, produces word/valid/error.
    modport slave (
        input  D,
        output Q,
        output V,
        output E
    );
endinterface

// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel receiver (start=1, WIDTH data bits LSB first, [even parity], stop=0); optional parity via SERIAL_DESERIALIZER_PARITY_EN.
// Latency: Q/V/E update on the stop-bit falling edge, WIDTH+1 edges after the start bit (WIDTH+2 with parity).
// Backpressure: none; every falling edge consumes one bit, V/E pulse for exactly one C period.
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                  C,
    input  logic                  Rn,
    serial_deserializer_if.slave  bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        PAR  = 2'd2,
`endif
        STOP = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] q_r;
    logic             v_r;
    logic             e_r;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    logic             perr;
`endif

    // Frame FSM: shift data, check parity/stop, and register the word and status pulses.
    always_ff @(negedge C or negedge Rn) begin
        if (!Rn) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
            q_r   <= '0;
            v_r   <= 1'b0;
            e_r   <= 1'b0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            perr  <= 1'b0;
`endif
        end else begin
            // Status pulses last one period unless re-asserted by a stop edge.
            v_r <= 1'b0;
            e_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.D) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                DATA: begin
                    sreg <= {bus.D, sreg[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        // Counter parks at zero rather than wrapping through the frame.
                        cnt <= '0;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                        state <= PAR;
`else
                        state <= STOP;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                PAR: begin
                    // Even parity: data ones plus the parity bit must be even.
                    perr  <= (bus.D != (^sreg));
                    state <= STOP;
                end
`endif
                STOP: begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                    if (!bus.D && !perr) begin
`else
                    if (!bus.D) begin
`endif
                        q_r <= sreg;
                        v_r <= 1'b1;
                    end else begin
                        // Bad frame: keep the previous word, flag it, no resync hunting.
                        e_r <= 1'b1;
                    end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
                    perr <= 1'b0;
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Q = q_r;
    assign bus.V = v_r;
    assign bus.E = e_r;

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: table-driven frames plus reset, back-to-back and abort sequences.
// Latency: expects Q/V/E at the stop edge, WIDTH+1 (or WIDTH+2) edges after the start edge.
// Backpressure: none; a scoreboard queue pairs each V/E pulse with the frame that caused it.
module tb_serial_deserializer;

    localparam int WIDTH = 8;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    localparam int LAT = WIDTH + 2;
`else
    localparam int LAT = WIDTH + 1;
`endif

    logic C;
    logic Rn;

    serial_deserializer_if #(.WIDTH(WIDTH)) sif ();

    serial_deserializer #(.WIDTH(WIDTH)) dut (
        .C   (C),
        .Rn  (Rn),
        .bus (sif.slave)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             par;
        logic             stop;
        logic             exp_v;
    } vec_t;

    typedef struct {
        logic             v;
        logic             e;
        logic [WIDTH-1:0] q;
        int               start_edge;
    } exp_t;

    exp_t             sb[$];
    int               v_edges[$];
    int               edge_cnt = 0;
    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] last_q = '0;

    // Falling-edge counter, used for latency and spacing checks.
    always @(negedge C) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every V/E pulse must match the oldest outstanding frame.
    always @(posedge C) begin
        #1;
        if (sif.V === 1'b1 || sif.E === 1'b1) begin
            if (sif.V === 1'b1) v_edges.push_back(edge_cnt);
            if (sb.size() == 0) begin
                check("unexpected_pulse", {30'd0, sif.V, sif.E}, 32'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check("valid", {31'd0, sif.V}, {31'd0, x.v});
                check("error", {31'd0, sif.E}, {31'd0, x.e});
                check("word",  32'(sif.Q), 32'(x.q));
                check("latency", 32'(edge_cnt - x.start_edge), 32'(LAT));
            end
        end
    end

    task automatic send_bit(input logic b);
        @(posedge C);
        sif.D = b;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] data, input logic par,
                              input logic stop, input logic exp_v);
        exp_t x;
        send_bit(1'b1);
        x.start_edge = edge_cnt + 1;
        x.v = exp_v;
        x.e = ~exp_v;
        if (exp_v) last_q = data;
        x.q = last_q;
        sb.push_back(x);
        for (int i = 0; i < WIDTH; i++) send_bit(data[i]);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bz) send_bit(1'b0); // parity field unused without the parity bit
`endif
        send_bit(stop);
    endtask

    vec_t vecs[$];

    initial begin
        // Inputs, then the hand-derived valid expectation. Parity column holds the correct even parity.
        vecs.push_back('{8'h81, 1'b0, 1'b1, 1'b0});   // bad stop right after reset: Q stays 0x00
        vecs.push_back('{8'hA5, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h01, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'h55, 1'b0, 1'b1, 1'b0});   // bad stop: Q keeps 0x80
        vecs.push_back('{8'hFE, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{8'h6D, 1'b1, 1'b0, 1'b1});
`ifdef SERIAL_DESERIALIZER_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b1});   // correct parity
        vecs.push_back('{8'h07, 1'b0, 1'b0, 1'b0});   // wrong parity: Q remains 0x07
        vecs.push_back('{8'hC3, 1'b1, 1'b0, 1'b0});   // wrong parity
`endif

        // Reset held for 3 edges with D toggling.
        Rn    = 1'b0;
        sif.D = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_bit(i[0] ? 1'b0 : 1'b1);
            #1;
            check("reset_q", 32'(sif.Q), 32'd0);
            check("reset_v", {31'd0, sif.V}, 32'd0);
            check("reset_e", {31'd0, sif.E}, 32'd0);
        end
        @(posedge C);
        sif.D = 1'b0;
        Rn    = 1'b1;
        repeat (3) send_bit(1'b0);

        // Table-driven frames, one idle edge between them.
        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop, vecs[i].exp_v);
            send_bit(1'b0);
        end
        repeat (3) send_bit(1'b0);
        check("table_drained", 32'(sb.size()), 32'd0);

        // Back-to-back frames with no idle edge between them.
        v_edges.delete();
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        repeat (3) send_bit(1'b0);
        check("b2b_count", 32'(v_edges.size()), 32'd2);
        if (v_edges.size() == 2)
            check("b2b_spacing", 32'(v_edges[1] - v_edges[0]), 32'(LAT + 1));
        check("b2b_last_q", 32'(sif.Q), 32'hFF);

        // Reset during the 4th data bit aborts the frame silently.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(posedge C);
        sif.D = 1'b1;
        Rn    = 1'b0;
        repeat (2) send_bit(1'b0);
        #1;
        check("abort_q_cleared", 32'(sif.Q), 32'd0);
        last_q = '0;
        @(posedge C);
        Rn    = 1'b1;
        sif.D = 1'b0;
        repeat (2) send_bit(1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        repeat (4) send_bit(1'b0);
        check("abort_drained", 32'(sb.size()), 32'd0);
        check("abort_final_q", 32'(sif.Q), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
